// File: rtl/dc_probe_pkg.sv
// Shared types for the DC probe averager: FSM state encoding and accumulator sizing.
package dc_probe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACCUM  = 2'd2,
        ST_CHECK  = 2'd3
    } state_e;

    // Summing 2**log2n samples of width bits can never exceed width+log2n bits.
    function automatic int acc_w(input int width, input int log2n);
        return width + log2n;
    endfunction

endpackage

// File: rtl/dc_window_cmp.sv
// Combinational window compare: in_window = |a - b| <= tol, without wrap at either rail.
module dc_window_cmp #(
    parameter int WIDTH = 12
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] tol,
    output logic             in_window
);

    logic [WIDTH-1:0] diff;

    // Subtract the smaller from the larger so the magnitude always fits in WIDTH bits.
    assign diff      = (a >= b) ? (a - b) : (b - a);
    assign in_window = (diff <= tol);

endmodule

// File: rtl/dc_probe_avg.sv
// DC level probe: discards SETTLE samples, averages 2**LOG2N samples, and checks the
// average against a captured reference within a captured tolerance.
//
// Sample handshake: a sample is consumed on a rising clk edge where smp_valid and
// smp_ready are both 1; smp_ready depends only on state, never on smp_valid.
module dc_probe_avg
    import dc_probe_pkg::*;
#(
    parameter int WIDTH  = 12,
    parameter int LOG2N  = 2,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] ref_data,
    input  logic [WIDTH-1:0] tol,
    input  logic             smp_valid,
    input  logic [WIDTH-1:0] smp_data,
    output logic             smp_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] avg,
    output logic             pass,
    output logic [1:0]       dbg_state
);

    localparam int ACC_W = acc_w(WIDTH, LOG2N);
    localparam int CNT_W = LOG2N + 1;
    localparam logic [7:0]       SETTLE_LAST = 8'((SETTLE > 0) ? (SETTLE - 1) : 0);
    localparam logic [CNT_W-1:0] ACC_LAST    = CNT_W'((1 << LOG2N) - 1);

    state_e           state;
    logic [ACC_W-1:0] acc;
    logic [7:0]       settle_cnt;
    logic [CNT_W-1:0] acc_cnt;
    logic [WIDTH-1:0] ref_q;
    logic [WIDTH-1:0] tol_q;
    logic [WIDTH-1:0] avg_next;
    logic             in_window;

    assign avg_next  = WIDTH'(acc >> LOG2N);
    assign smp_ready = (state == ST_SETTLE) || (state == ST_ACCUM);
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    dc_window_cmp #(.WIDTH(WIDTH)) u_cmp (
        .a         (avg_next),
        .b         (ref_q),
        .tol       (tol_q),
        .in_window (in_window)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            acc        <= '0;
            settle_cnt <= '0;
            acc_cnt    <= '0;
            ref_q      <= '0;
            tol_q      <= '0;
            avg        <= '0;
            pass       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ref_q      <= ref_data;
                        tol_q      <= tol;
                        acc        <= '0;
                        settle_cnt <= '0;
                        acc_cnt    <= '0;
                        state      <= (SETTLE == 0) ? ST_ACCUM : ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (smp_valid) begin
                        if (settle_cnt == SETTLE_LAST) begin
                            state <= ST_ACCUM;
                        end else begin
                            settle_cnt <= settle_cnt + 8'd1;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (smp_valid) begin
                        acc     <= acc + ACC_W'(smp_data);
                        acc_cnt <= acc_cnt + CNT_W'(1);
                        if (acc_cnt == ACC_LAST) begin
                            state <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    // Result and verdict land together with the done pulse.
                    avg   <= avg_next;
                    pass  <= in_window;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dc_probe_avg.sv
// Directed bench for dc_probe_avg: expected {pass, avg} queued at start, checked on done.
module tb_dc_probe_avg;
    import dc_probe_pkg::*;

    localparam int W = 12;
    localparam int L = 2;
    localparam int S = 2;
    localparam int N = 4;

    typedef logic [W-1:0] smp6_t [6];

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] ref_data;
    logic [W-1:0] tol;
    logic         smp_valid;
    logic [W-1:0] smp_data;
    logic         smp_ready;
    logic         busy;
    logic         done;
    logic [W-1:0] avg;
    logic         pass;
    logic [1:0]   dbg_state;

    logic [W:0]   exp_q[$];
    logic [W:0]   exp_e;
    int           n_vec  = 0;
    int           n_miss = 0;
    int           n_done = 0;

    dc_probe_avg #(.WIDTH(W), .LOG2N(L), .SETTLE(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ref_data  (ref_data),
        .tol       (tol),
        .smp_valid (smp_valid),
        .smp_data  (smp_data),
        .smp_ready (smp_ready),
        .busy      (busy),
        .done      (done),
        .avg       (avg),
        .pass      (pass),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] r, input logic [W-1:0] t,
                                         input smp6_t s);
        int sum;
        int a;
        int d;
        sum = 0;
        for (int i = S; i < S + N; i++) sum += int'(s[i]);
        a = sum / N;
        d = (a > int'(r)) ? (a - int'(r)) : (int'(r) - a);
        return {(d <= int'(t)), W'(a)};
    endfunction

    // Scoreboard: every done pulse must consume one expected result.
    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            check("done_expected", 16'(exp_q.size() != 0), 16'd1);
            if (exp_q.size() != 0) begin
                exp_e = exp_q.pop_front();
                check("avg", 16'(avg), 16'(exp_e[W-1:0]));
                check("pass", 16'(pass), 16'(exp_e[W]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic [W-1:0] r, input logic [W-1:0] t);
        @(negedge clk);
        start    = 1'b1;
        ref_data = r;
        tol      = t;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", 16'(busy), 16'd1);
        check("settle_after_start", 16'(dbg_state), 16'(ST_SETTLE));
    endtask

    task automatic send_sample(input logic [W-1:0] d);
        int b;
        b         = 0;
        smp_valid = 1'b1;
        smp_data  = d;
        @(negedge clk);
        while (!smp_ready && b < 20) begin
            @(negedge clk);
            b++;
        end
        check("ready_timeout", 16'(smp_ready), 16'd1);
        @(posedge clk);
        #1;
        smp_valid = 1'b0;
    endtask

    task automatic run_meas(input logic [W-1:0] r, input logic [W-1:0] t, input smp6_t s,
                            input int gap, input int inj_at);
        do_start(r, t);
        exp_q.push_back(model(r, t, s));
        for (int i = 0; i < 6; i++) begin
            if (i == inj_at) begin
                start    = 1'b1;
                ref_data = '0;
                tol      = '0;
                @(posedge clk);
                #1;
                start = 1'b0;
                check("ignored_start_state", 16'(dbg_state), 16'(ST_ACCUM));
            end
            send_sample(s[i]);
            if (gap > 0 && i < 5) begin
                repeat (gap) @(posedge clk);
                #1;
                check("stall_state", 16'(dbg_state),
                      (i + 1 < S) ? 16'(ST_SETTLE) : 16'(ST_ACCUM));
            end
        end
        check("check_state", 16'(dbg_state), 16'(ST_CHECK));
        check("done_early", 16'(done), 16'd0);
        @(posedge clk);
        #1;
        check("done_latency", 16'(done), 16'd1);
        check("idle_on_done", 16'(busy), 16'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        ref_data  = '0;
        tol       = '0;
        smp_valid = 1'b0;
        smp_data  = '0;
        #1;
        check("rst_ready", 16'(smp_ready), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        check("rst_avg", 16'(avg), 16'd0);
        check("rst_pass", 16'(pass), 16'd0);
        check("rst_state", 16'(dbg_state), 16'(ST_IDLE));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Back-to-back samples, average inside window.
        run_meas(12'd1000, 12'd8, '{12'd0, 12'd0, 12'd1000, 12'd1002, 12'd998, 12'd1004}, 0, -1);
        // Average well outside window.
        run_meas(12'd1000, 12'd8, '{12'd5, 12'd5, 12'd1020, 12'd1020, 12'd1020, 12'd1020}, 0, -1);
        // Full-scale samples with 3-cycle stalls, tol=0 exact match at the top rail.
        run_meas(12'd4095, 12'd0, '{12'd0, 12'd0, 12'd4095, 12'd4095, 12'd4095, 12'd4095}, 3, -1);
        // Second start during ACCUM must not replace ref/tol.
        run_meas(12'd500, 12'd3, '{12'd9, 12'd9, 12'd498, 12'd499, 12'd500, 12'd501}, 0, 3);
        // Start issued in the done cycle begins a new measurement.
        check("done_at_restart", 16'(done), 16'd1);
        run_meas(12'd2000, 12'd100, '{12'd1, 12'd2, 12'd2000, 12'd2050, 12'd1950, 12'd2100}, 0, -1);
        // ref=0, difference exactly equal to tol.
        run_meas(12'd0, 12'd3, '{12'd4095, 12'd4095, 12'd3, 12'd3, 12'd4, 12'd4}, 0, -1);
        // tol=0 off by one at the top rail.
        run_meas(12'd4095, 12'd0, '{12'd0, 12'd0, 12'd4094, 12'd4094, 12'd4094, 12'd4094}, 1, -1);

        // Abandon a measurement with reset after the third accepted sample.
        do_start(12'd100, 12'd5);
        send_sample(12'd50);
        send_sample(12'd50);
        send_sample(12'd60);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 16'(smp_ready), 16'd0);
        check("mid_rst_busy", 16'(busy), 16'd0);
        check("mid_rst_done", 16'(done), 16'd0);
        check("mid_rst_avg", 16'(avg), 16'd0);
        check("mid_rst_pass", 16'(pass), 16'd0);
        check("mid_rst_state", 16'(dbg_state), 16'(ST_IDLE));
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("no_done_after_rst", 16'(done), 16'd0);
        run_meas(12'd11, 12'd0, '{12'd7, 12'd7, 12'd10, 12'd11, 12'd12, 12'd13}, 0, -1);

        repeat (4) @(negedge clk);
        check("queue_drained", 16'(exp_q.size()), 16'd0);
        check("done_count", 16'(n_done), 16'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
